// File: rtl/host_wr_if.sv
// host_wr_if: host byte-write port feeding chrowbuf/palette/fontmem through a commit FIFO; HOST_AUTOINC_EN enables address auto-increment
module host_wr_if #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_ncs,
  input  logic        host_nwr,
  input  logic [1:0]  host_reg,
  input  logic [7:0]  host_data,
  input  logic        wr_hold,
  output logic        host_full,
  output logic        overflow_err,
  output logic        chrowbuf_wr,
  output logic [7:0]  chrowbuf_wr_addr,
  output logic [15:0] chrowbuf_wr_data,
  output logic        palette_wr,
  output logic [7:0]  palette_wr_addr,
  output logic [15:0] palette_wr_data,
  output logic        fontmem_wr,
  output logic [11:0] fontmem_wr_addr,
  output logic [7:0]  fontmem_wr_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, WRITE} state_t;
  typedef struct packed {logic [1:0] tgt; logic [11:0] a; logic [15:0] d;} entry_t;
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0] dlo_q, dlo_d;
  entry_t mem_q [FIFO_DEPTH];
  entry_t mem_d [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic full_q, full_d, ovf_q, ovf_d;
  logic [2:0] wr_q, wr_d;
  logic [11:0] oa_q, oa_d;
  logic [15:0] od_q, od_d;
  logic accept, push_req, push, pop;
  entry_t head;
  always_comb begin
    sync_d = {sync_q[1:0], ~host_ncs & ~host_nwr};
    accept = sync_q[1] & ~sync_q[2];
    push_req = accept & (host_reg == 2'd3);
    pop = (state_q == IDLE) && (cnt_q != '0) && !wr_hold;
    push = push_req && ((cnt_q < DEPTH_C) || pop);
    head = mem_q[rp_q];
    mem_d = mem_q;
    if (push) mem_d[wp_q] = {addr_q[15:14], addr_q[11:0], host_data, dlo_q};
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    full_d = cnt_d == DEPTH_C;
    ovf_d = ovf_q | (push_req & ~push);
    addr_d = (accept && host_reg == 2'd0) ? {addr_q[15:8], host_data} :
             (accept && host_reg == 2'd1) ? {host_data, addr_q[7:0]} : addr_q;
`ifdef HOST_AUTOINC_EN
    if (push) addr_d[11:0] = addr_q[11:0] + 12'd1;
`endif
    dlo_d = (accept && host_reg == 2'd2) ? host_data : dlo_q;
    state_d = pop ? WRITE : IDLE;
    oa_d = pop ? head.a : oa_q;
    od_d = pop ? head.d : od_q;
    // {fontmem, palette, chrowbuf}; target 3 pops silently
    wr_d = pop ? {head.tgt != 2'd2, head.tgt != 2'd1, head.tgt != 2'd0} : 3'b111;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      addr_q <= '0;
      dlo_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_q <= 3'b111;
      oa_q <= '0;
      od_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      addr_q <= addr_d;
      dlo_q <= dlo_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      wr_q <= wr_d;
      oa_q <= oa_d;
      od_q <= od_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign host_full = full_q;
  assign overflow_err = ovf_q;
  assign chrowbuf_wr = wr_q[0];
  assign palette_wr = wr_q[1];
  assign fontmem_wr = wr_q[2];
  assign chrowbuf_wr_addr = oa_q[7:0];
  assign palette_wr_addr = oa_q[7:0];
  assign fontmem_wr_addr = oa_q;
  assign chrowbuf_wr_data = od_q;
  assign palette_wr_data = od_q;
  assign fontmem_wr_data = od_q[7:0];
endmodule

// File: tb/tb_host_wr_if.sv
// tb_host_wr_if: directed vector bench for host_wr_if
module tb_host_wr_if;
  logic clk = 0, rst = 1, host_ncs = 1, host_nwr = 1, wr_hold = 0;
  logic [1:0] host_reg = 0;
  logic [7:0] host_data = 0;
  logic host_full, overflow_err, chrowbuf_wr, palette_wr, fontmem_wr;
  logic [7:0] chrowbuf_wr_addr, palette_wr_addr, fontmem_wr_data;
  logic [15:0] chrowbuf_wr_data, palette_wr_data;
  logic [11:0] fontmem_wr_addr;
  host_wr_if dut (
    .clk(clk), .rst(rst), .host_ncs(host_ncs), .host_nwr(host_nwr),
    .host_reg(host_reg), .host_data(host_data), .wr_hold(wr_hold),
    .host_full(host_full), .overflow_err(overflow_err),
    .chrowbuf_wr(chrowbuf_wr), .chrowbuf_wr_addr(chrowbuf_wr_addr), .chrowbuf_wr_data(chrowbuf_wr_data),
    .palette_wr(palette_wr), .palette_wr_addr(palette_wr_addr), .palette_wr_data(palette_wr_data),
    .fontmem_wr(fontmem_wr), .fontmem_wr_addr(fontmem_wr_addr), .fontmem_wr_data(fontmem_wr_data)
  );
  always #5 clk = ~clk;
  typedef struct {logic [1:0] t; logic [11:0] a; logic [15:0] d;} wr_t;
  typedef struct {logic [7:0] ahi, alo, dlo, dhi; logic [1:0] et; logic [11:0] ea; logic [15:0] ed;} vec_t;
  wr_t log_q[$];
  int n_vec = 0, n_err = 0, pw_err = 0;
  logic prev_low = 0;
  always @(posedge clk) begin
    #2;
    if (chrowbuf_wr === 1'b0) log_q.push_back('{2'd0, {4'h0, chrowbuf_wr_addr}, chrowbuf_wr_data});
    if (palette_wr === 1'b0) log_q.push_back('{2'd1, {4'h0, palette_wr_addr}, palette_wr_data});
    if (fontmem_wr === 1'b0) log_q.push_back('{2'd2, fontmem_wr_addr, {8'h0, fontmem_wr_data}});
    if ((chrowbuf_wr === 1'b0) + (palette_wr === 1'b0) + (fontmem_wr === 1'b0) > 1) pw_err++;
    if (prev_low && ({chrowbuf_wr, palette_wr, fontmem_wr} !== 3'b111)) pw_err++;
    prev_low = {chrowbuf_wr, palette_wr, fontmem_wr} !== 3'b111;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic hw(input logic [1:0] r, input logic [7:0] d);
    @(negedge clk);
    host_reg = r; host_data = d; host_ncs = 0; host_nwr = 0;
    repeat (4) @(negedge clk);
    host_ncs = 1; host_nwr = 1;
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_wr(input string name, input int idx, input logic [1:0] t, input logic [11:0] a, input logic [15:0] d);
    if (idx >= log_q.size()) chk({name, "_missing"}, 0, 1);
    else begin
      chk({name, "_tgt"}, log_q[idx].t, t);
      chk({name, "_addr"}, log_q[idx].a, a);
      chk({name, "_data"}, log_q[idx].d, d);
    end
  endtask
  vec_t vt[6];
  int n0;
  logic [11:0] a2;
  initial begin
    vt[0] = '{8'h40, 8'h05, 8'hC0, 8'h0C, 2'd1, 12'h005, 16'h0CC0};
    vt[1] = '{8'h00, 8'h12, 8'h34, 8'h56, 2'd0, 12'h012, 16'h5634};
    vt[2] = '{8'h8A, 8'hBC, 8'h5A, 8'hFF, 2'd2, 12'hABC, 16'h005A};
    vt[3] = '{8'hC0, 8'h01, 8'h11, 8'h22, 2'd3, 12'h000, 16'h0000};
    vt[4] = '{8'h3F, 8'h33, 8'h01, 8'h02, 2'd0, 12'h033, 16'h0201};
    vt[5] = '{8'h40, 8'hFF, 8'hAA, 8'h55, 2'd1, 12'h0FF, 16'h55AA};
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_wr", {chrowbuf_wr, palette_wr, fontmem_wr}, 3'b111);
    chk("rst_full", host_full, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_addr", {chrowbuf_wr_addr, fontmem_wr_addr}, 0);
    chk("rst_data", {chrowbuf_wr_data, fontmem_wr_data}, 0);
    repeat (100) @(negedge clk);
    chk("rst_quiet", log_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      n0 = log_q.size();
      hw(1, vt[i].ahi); hw(0, vt[i].alo); hw(2, vt[i].dlo); hw(3, vt[i].dhi);
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_count", i), log_q.size() - n0, vt[i].et == 3 ? 0 : 1);
      if (vt[i].et != 3) chk_wr($sformatf("v%0d", i), n0, vt[i].et, vt[i].ea, vt[i].ed);
    end
    n0 = log_q.size();
    hw(1, 8'h8F); hw(0, 8'hFF); hw(2, 8'h41); hw(3, 8'h00); hw(2, 8'h42); hw(3, 8'h00);
    repeat (8) @(negedge clk);
    chk("inc_count", log_q.size() - n0, 2);
    chk_wr("inc0", n0, 2, 12'hFFF, 16'h0041);
`ifdef HOST_AUTOINC_EN
    chk_wr("inc1", n0 + 1, 2, 12'h000, 16'h0042);
`else
    chk_wr("inc1", n0 + 1, 2, 12'hFFF, 16'h0042);
`endif
    wr_hold = 1;
    n0 = log_q.size();
    hw(1, 8'h00); hw(0, 8'h0A);
    for (int i = 1; i <= 5; i++) begin
      hw(2, 8'(i)); hw(3, 8'h00);
      if (i == 3) chk("ovf_full3", host_full, 0);
      if (i == 4) begin
        chk("ovf_full4", host_full, 1);
        chk("ovf_err4", overflow_err, 0);
      end
    end
    chk("ovf_full5", host_full, 1);
    chk("ovf_err5", overflow_err, 1);
    chk("ovf_held", log_q.size() - n0, 0);
    wr_hold = 0;
    repeat (20) @(negedge clk);
    chk("ovf_count", log_q.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef HOST_AUTOINC_EN
      a2 = 12'h00A + 12'(i);
`else
      a2 = 12'h00A;
`endif
      chk_wr($sformatf("ovf%0d", i), n0 + i, 0, a2, 16'(i + 1));
    end
    chk("ovf_full_clr", host_full, 0);
    chk("ovf_sticky", overflow_err, 1);
    wr_hold = 1;
    hw(1, 8'h40); hw(0, 8'h01);
    for (int i = 1; i <= 3; i++) begin hw(2, 8'(i)); hw(3, 8'h00); end
    n0 = log_q.size();
    wr_hold = 0;
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (palette_wr === 1'b0) break;
      end
      chk("rst6_seen", k < 50, 1);
    end
    rst = 1;
    @(negedge clk);
    chk("rst6_wr", palette_wr, 1);
    @(negedge clk);
    rst = 0;
    n0 = log_q.size() - n0;
    chk("rst6_before", n0, 1);
    n0 = log_q.size();
    repeat (30) @(negedge clk);
    chk("rst6_quiet", log_q.size() - n0, 0);
    chk("rst6_full", host_full, 0);
    chk("rst6_ovf", overflow_err, 0);
    chk("pulse_shape", pw_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
